// File: rtl/ddr_cmd_scheduler_pkg.sv
// Shared types and constants for the DDR command scheduler.
//   input_data_type : command payload (address, write data, direction)
//   sched_state_e   : issue FSM states
//   rr_pick         : two-way round-robin winner selection
package ddr_package;

  localparam int unsigned ADDR_W         = 28;
  localparam int unsigned DATA_W         = 64;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_CNT_W      = 16;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } rw_e;

  typedef struct packed {
    logic [ADDR_W-1:0] physical_addr;
    logic [DATA_W-1:0] data_wr;
    rw_e               rw;
  } input_data_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

  // Winner index: the port not last granted when both are pending,
  // otherwise whichever port is pending (port 1 iff port 0 is empty).
  function automatic logic rr_pick(input logic ne0, input logic ne1, input logic last);
    return (ne0 && ne1) ? ~last : ~ne0;
  endfunction

endpackage

// File: rtl/ddr_cmd_scheduler_if.sv
// Requester-side bundle for the two command ports.
//   reqN_valid / reqN_data : requester offers a command
//   reqN_ready             : scheduler FIFO N can accept (combinational !full)
// master = requester side, slave = scheduler side.
interface ddr_cmd_scheduler_if;
  import ddr_package::*;

  logic           req0_valid;
  input_data_type req0_data;
  logic           req0_ready;
  logic           req1_valid;
  input_data_type req1_data;
  logic           req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/ddr_req_fifo.sv
// Per-requester command queue.
//   clk, rst_n : clock, async active-low reset (empties the queue)
//   push, din  : write din when not full
//   pop        : drop head entry when not empty
//   full/empty : occupancy flags, registered-pointer derived
//   dout       : head entry (valid when !empty)
module ddr_req_fifo
  import ddr_package::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter type         T     = input_data_type
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     din,
  output logic full,
  output logic empty,
  output T     dout
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned PW    = PTR_W + 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Push is refused when full even if a pop happens the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for pointers and storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = din;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; entries are only read behind a valid pointer.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// Two-port round-robin DDR command scheduler.
//   clock_t, reset_n : clock, async active-low reset
//   req_if (slave)   : two requester ports, each with its own FIFO
//   dev_busy         : controller busy, blocks issue
//   next_cmd         : controller can take a command
//   act_cmd          : one-cycle issue strobe
//   data, cmd_src    : last issued command and its port, held until next issue
//   cmd_count        : wrapping count of issued commands
module ddr_cmd_scheduler
  import ddr_package::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                 clock_t,
  input  logic                 reset_n,
  ddr_cmd_scheduler_if.slave   req_if,
  input  logic                 dev_busy,
  input  logic                 next_cmd,
  output logic                 act_cmd,
  output input_data_type       data,
  output logic                 cmd_src,
  output logic [CNT_W-1:0]     cmd_count
);

  logic           full0, empty0, push0, pop0;
  logic           full1, empty1, push1, pop1;
  input_data_type dout0, dout1;

  sched_state_e   state_q, state_d;
  logic           act_cmd_q, act_cmd_d;
  input_data_type data_q, data_d;
  logic           cmd_src_q, cmd_src_d;
  logic [CNT_W-1:0] cmd_count_q, cmd_count_d;
  logic           last_grant_q, last_grant_d;

  logic           grant;
  logic           ctrl_ready;
  logic           any_pending;

  assign req_if.req0_ready = !full0;
  assign req_if.req1_ready = !full1;
  assign push0 = req_if.req0_valid && !full0;
  assign push1 = req_if.req1_valid && !full1;

  ddr_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (input_data_type)
  ) u_fifo0 (
    .clk   (clock_t),
    .rst_n (reset_n),
    .push  (push0),
    .pop   (pop0),
    .din   (req_if.req0_data),
    .full  (full0),
    .empty (empty0),
    .dout  (dout0)
  );

  ddr_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (input_data_type)
  ) u_fifo1 (
    .clk   (clock_t),
    .rst_n (reset_n),
    .push  (push1),
    .pop   (pop1),
    .din   (req_if.req1_data),
    .full  (full1),
    .empty (empty1),
    .dout  (dout1)
  );

  assign any_pending = !empty0 || !empty1;
  assign ctrl_ready  = next_cmd && !dev_busy;
  assign grant       = rr_pick(!empty0, !empty1, last_grant_q);

  // Issue FSM: IDLE pops the winner, ISSUE drops the strobe, WAIT holds
  // until the controller is ready again. Gives a 3-cycle minimum spacing.
  always_comb begin
    state_d      = state_q;
    act_cmd_d    = 1'b0;
    data_d       = data_q;
    cmd_src_d    = cmd_src_q;
    cmd_count_d  = cmd_count_q;
    last_grant_d = last_grant_q;
    pop0         = 1'b0;
    pop1         = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_pending && ctrl_ready) begin
          pop0         = !grant;
          pop1         = grant;
          data_d       = grant ? dout1 : dout0;
          cmd_src_d    = grant;
          last_grant_d = grant;
          act_cmd_d    = 1'b1;
          cmd_count_d  = cmd_count_q + CNT_W'(1);
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (ctrl_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so port 0 wins the first arbitration.
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      act_cmd_q    <= 1'b0;
      data_q       <= '0;
      cmd_src_q    <= 1'b0;
      cmd_count_q  <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      act_cmd_q    <= act_cmd_d;
      data_q       <= data_d;
      cmd_src_q    <= cmd_src_d;
      cmd_count_q  <= cmd_count_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign act_cmd   = act_cmd_q;
  assign data      = data_q;
  assign cmd_src   = cmd_src_q;
  assign cmd_count = cmd_count_q;

endmodule

// File: doc/ddr_cmd_scheduler.md
DDR_CMD_SCHEDULER -- requirements
Module: ddr_cmd_scheduler

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning entries per requester FIFO, a power of two and at least 2.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the issued-command counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clock_t: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-005 Port reset_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Ports req0_valid / req1_valid: input, 1 bit each, requester has a command.
REQ-007 Ports req0_data / req1_data: input, input_data_type each (physical_addr, data_wr, rw), command payload.
REQ-008 Ports req0_ready / req1_ready: output, 1 bit each, high when that FIFO is not full.
REQ-009 Port dev_busy: input, 1 bit, DDR controller busy.
REQ-010 Port next_cmd: input, 1 bit, DDR controller can accept a command.
REQ-011 Port act_cmd: output, 1 bit, one-cycle issue strobe.
REQ-012 Port data: output, input_data_type, issued command; valid while act_cmd is high and held until the next issue.
REQ-013 Port cmd_src: output, 1 bit, requester index of the last issued command.
REQ-014 Port cmd_count: output, CNT_W bits, total commands issued.

Function
REQ-015 Each port SHALL push on reqN_valid && reqN_ready, with the entry visible to the arbiter the next cycle.
REQ-016 reqN_ready SHALL be combinational !full, so a push is never accepted into a full FIFO, including a cycle in which that FIFO is popped.
REQ-017 A simultaneous push and pop on a non-full FIFO SHALL leave its occupancy unchanged and preserve FIFO order.
REQ-018 FSM states SHALL be IDLE, ISSUE and WAIT.
REQ-019 IDLE: when any FIFO is non-empty, next_cmd=1 and dev_busy=0, the block SHALL pop the winner, register data and cmd_src, set act_cmd, and go to ISSUE.
REQ-020 ISSUE: the block SHALL clear act_cmd and go to WAIT unconditionally.
REQ-021 WAIT: the block SHALL go to IDLE when next_cmd=1 and dev_busy=0, and otherwise stay in WAIT.
REQ-022 Minimum issue spacing SHALL be 3 cycles, and act_cmd SHALL never be high on two consecutive cycles.
REQ-023 Arbitration SHALL be round-robin: when both FIFOs are non-empty the winner is the port not last granted, and when one FIFO is non-empty that port wins.
REQ-024 The round-robin pointer SHALL update only on an actual pop.
REQ-025 cmd_count SHALL increment on each act_cmd assertion and wrap from 2^CNT_W-1 to 0.
REQ-026 Ordering SHALL be preserved per port only; no read/write reordering or address hazard checking is performed.

Reset
REQ-027 While reset_n=0, act_cmd=0, data=0, cmd_src=0, cmd_count=0, FSM=IDLE, both FIFOs empty, reqN_ready=1, and last-grant=1 so that port 0 wins first.
REQ-028 Reset asserted mid-operation, including during ISSUE with act_cmd high, SHALL drop act_cmd asynchronously and discard all queued entries.
REQ-029 The first issue after deassertion SHALL occur no earlier than the second rising edge after reset_n rises.

Structure
REQ-030 The sched_state_e enum (IDLE, ISSUE, WAIT) and the default FIFO_DEPTH constant SHALL be defined in ddr_package alongside input_data_type.
REQ-031 The per-port queue SHALL be a sub-module, ddr_req_fifo, parameterised by depth and payload type, exposing push, pop, full, empty and dout, and instantiated twice.
REQ-032 The arbiter and FSM SHALL be in ddr_cmd_scheduler itself.

Verification
REQ-033 Single command: push {addr=0x0000100, data=0xDEADBEEF_00000001, rw=WRITE} on port 0 with next_cmd=1 and dev_busy=0 -> act_cmd pulses 1 cycle with that data, cmd_src=0, cmd_count=1.
REQ-034 Fairness: 3 commands queued on each port, controller always ready -> issue order p0,p1,p0,p1,p0,p1, spacing exactly 3 cycles, cmd_count=6.
REQ-035 Backpressure: dev_busy=1 held while port 1 pushes 5 commands -> req1_ready falls after the 4th; with dev_busy=0 all 4 accepted commands are issued in order, and the 5th push is accepted once req1_ready rises.
REQ-036 Stall in WAIT: after an issue, next_cmd=0 for 10 cycles -> no act_cmd; the next act_cmd comes 1 cycle after IDLE is re-entered.
REQ-037 Reset mid-flight: reset_n=0 during ISSUE with 2 entries queued -> act_cmd=0 immediately, no further issues after release, cmd_count=0.
REQ-038 Wrap: CNT_W=4 with 17 commands -> cmd_count reads 1.
